// File: rtl/opsel_pipe.sv
// -----------------------------------------------------------------------------
// opsel_pipe
//
// Parametrised N-way operand-select register for the EX-stage datapath.
// Picks one of NUM_IN packed operand sources by index and registers the
// result behind a valid/ready handshake with stall hold and flush.
// Out-of-range selects fall back to source 0 (and report sel_o = 0).
//
// Parameters:
//   WIDTH  operand width in bits
//   NUM_IN number of sources (2..16)
//   SEL_W  select width, 2**SEL_W >= NUM_IN
//   ERR_W  width of the out-of-range select counter
//
// Ports:
//   clk_i      in   clock, rising edge
//   rst_i      in   synchronous active-high reset
//   valid_i    in   upstream offers a transaction
//   ready_o    out  transaction accepted this cycle if valid_i is high
//   data_i     in   packed sources, source k = data_i[k*WIDTH +: WIDTH]
//   select_i   in   source index
//   flush_i    in   drop the held and the incoming transaction
//   valid_o    out  data_o/sel_o carry a valid result
//   ready_i    in   downstream consumes the result
//   data_o     out  registered selected operand
//   sel_o      out  registered effective index
//   err_cnt_o  out  saturating count of accepted out-of-range selects
//
// Build option:
//   OPSEL_ERRCNT_EN  when defined, err_cnt_o is a real saturating counter;
//                    otherwise it is tied to zero and no counter is built.
// -----------------------------------------------------------------------------
module opsel_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = 2,
  parameter int ERR_W  = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [NUM_IN*WIDTH-1:0] data_i,
  input  logic [SEL_W-1:0]        select_i,
  input  logic                    flush_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [WIDTH-1:0]        data_o,
  output logic [SEL_W-1:0]        sel_o,
  output logic [ERR_W-1:0]        err_cnt_o
);

  // One extra bit so NUM_IN == 2**SEL_W is representable in the compare.
  localparam logic [SEL_W:0] NUM_IN_W = (SEL_W+1)'(NUM_IN);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] sel_q, sel_d;

  logic             in_range;
  logic             accept;
  logic [SEL_W-1:0] eff_sel;
  logic [WIDTH-1:0] eff_data;

  // Effective index and selected source
  assign in_range = ({1'b0, select_i} < NUM_IN_W);
  assign eff_sel  = in_range ? select_i : '0;

  always_comb begin
    eff_data = data_i[WIDTH-1:0];
    for (int k = 1; k < NUM_IN; k++) begin
      if (eff_sel == SEL_W'(k)) eff_data = data_i[k*WIDTH +: WIDTH];
    end
  end

  // Handshake: ready depends only on flush, held valid and downstream ready.
  assign ready_o = !flush_i && (!valid_q || ready_i);
  assign accept  = valid_i && ready_o;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    sel_d   = sel_q;
    if (flush_i) begin
      // Payload registers keep their last value; only valid is dropped.
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      data_d  = eff_data;
      sel_d   = eff_sel;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Output register stage
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign sel_o   = sel_q;

`ifdef OPSEL_ERRCNT_EN
  logic [ERR_W-1:0] err_q, err_d;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    if (v == {ERR_W{1'b1}}) return v;
    return v + ERR_W'(1);
  endfunction

  // Counts only accepted offers, so flushed or stalled offers never count.
  always_comb begin
    err_d = err_q;
    if (accept && !in_range) err_d = sat_inc(err_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) err_q <= '0;
    else       err_q <= err_d;
  end

  assign err_cnt_o = err_q;
`else
  assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_opsel_pipe.sv
module tb_opsel_pipe;
  localparam int WIDTH  = 32;
  localparam int NUM_IN = 3;
  localparam int SEL_W  = 2;
  localparam int ERR_W  = 8;
  localparam int W_WIDTH = 64;
  localparam int W_NUM   = 16;
  localparam int W_SEL   = 4;
  localparam logic [63:0] W_STEP = 64'h0101010101010101;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst_i, valid_i, flush_i, ready_i;
  logic                    ready_o, valid_o;
  logic [NUM_IN*WIDTH-1:0] data_i;
  logic [SEL_W-1:0]        select_i, sel_o;
  logic [WIDTH-1:0]        data_o;
  logic [ERR_W-1:0]        err_cnt_o;

  logic                      w_valid_i, w_flush_i, w_ready_i, w_ready_o, w_valid_o;
  logic [W_NUM*W_WIDTH-1:0]  w_data_i;
  logic [W_SEL-1:0]          w_select_i, w_sel_o;
  logic [W_WIDTH-1:0]        w_data_o;
  logic [ERR_W-1:0]          w_err_cnt_o;

  opsel_pipe #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W), .ERR_W(ERR_W)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_i(data_i), .select_i(select_i), .flush_i(flush_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .sel_o(sel_o),
    .err_cnt_o(err_cnt_o)
  );

  opsel_pipe #(.WIDTH(W_WIDTH), .NUM_IN(W_NUM), .SEL_W(W_SEL), .ERR_W(ERR_W)) u_wide (
    .clk_i(clk), .rst_i(rst_i), .valid_i(w_valid_i), .ready_o(w_ready_o),
    .data_i(w_data_i), .select_i(w_select_i), .flush_i(w_flush_i),
    .valid_o(w_valid_o), .ready_i(w_ready_i), .data_o(w_data_o), .sel_o(w_sel_o),
    .err_cnt_o(w_err_cnt_o)
  );

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SEL_W-1:0] sel;
  } res_t;

  int   checks = 0;
  int   errors = 0;
  res_t exp_q[$];
  res_t last;
  logic mdl_valid;
  logic [ERR_W-1:0] mdl_err;

  task automatic set_in(input logic v, input logic [SEL_W-1:0] s,
                        input logic f, input logic r);
    valid_i  = v;
    select_i = s;
    flush_i  = f;
    ready_i  = r;
    #1;
  endtask

  task automatic set_src(input logic [WIDTH-1:0] s0, input logic [WIDTH-1:0] s1,
                         input logic [WIDTH-1:0] s2);
    data_i = {s2, s1, s0};
  endtask

  // Advance one clock, updating the reference model from the inputs that
  // were presented before the edge.
  task automatic tick();
    logic             exp_rdy;
    logic [SEL_W-1:0] eff;
    res_t             r;
    exp_rdy = !flush_i && (!mdl_valid || ready_i);
    eff     = (int'(select_i) < NUM_IN) ? select_i : '0;
    r.data  = data_i[int'(eff)*WIDTH +: WIDTH];
    r.sel   = eff;
    @(posedge clk);
    if (rst_i) begin
      exp_q.delete();
      mdl_err = '0;
      last    = '0;
    end else begin
      if ((flush_i || (mdl_valid && ready_i)) && exp_q.size() > 0) void'(exp_q.pop_front());
      if (valid_i && exp_rdy) begin
        exp_q.push_back(r);
        last = r;
`ifdef OPSEL_ERRCNT_EN
        if (int'(select_i) >= NUM_IN && mdl_err != {ERR_W{1'b1}}) mdl_err = mdl_err + 1'b1;
`endif
      end
    end
    mdl_valid = (exp_q.size() != 0);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    set_in(1'b0, '0, 1'b0, 1'b1);
    tick();
    tick();
    rst_i = 1'b0;
    #1;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", valid_o); end
    checks++; if (data_o !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", data_o); end
    checks++; if (sel_o !== '0) begin errors++; $display("FAIL reset_sel: got %0d want 0", sel_o); end
    checks++; if (err_cnt_o !== '0) begin errors++; $display("FAIL reset_err: got %0d want 0", err_cnt_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", ready_o); end
  endtask

  task automatic test_basic();
    set_src(32'h11, 32'h22, 32'h33);
    for (int s = 0; s < 3; s++) begin
      set_in(1'b1, SEL_W'(s), 1'b0, 1'b1);
      checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL basic_ready: got %0b want 1", ready_o); end
      tick();
      checks++;
      if (valid_o !== 1'b1 || exp_q.size() == 0) begin
        errors++; $display("FAIL basic_valid: got %0b want 1", valid_o);
      end else if (data_o !== exp_q[0].data || sel_o !== exp_q[0].sel) begin
        errors++; $display("FAIL basic_data: got %h/%0d want %h/%0d", data_o, sel_o, exp_q[0].data, exp_q[0].sel);
      end
    end
    checks++; if (data_o !== 32'h33) begin errors++; $display("FAIL basic_last: got %h want 33", data_o); end
    set_in(1'b0, '0, 1'b0, 1'b1);
    tick();
    checks++; if (valid_o !== 1'b0 || data_o !== 32'h33) begin errors++; $display("FAIL basic_drain: got %0b/%h want 0/33", valid_o, data_o); end
  endtask

  task automatic test_out_of_range();
    logic [ERR_W-1:0] exp_sat;
    set_src(32'h11, 32'h22, 32'h33);
    set_in(1'b1, 2'd3, 1'b0, 1'b1);
    tick();
    checks++; if (valid_o !== 1'b1 || data_o !== 32'h11 || sel_o !== 2'd0) begin
      errors++; $display("FAIL oor_fallback: got %0b/%h/%0d want 1/11/0", valid_o, data_o, sel_o);
    end
    checks++; if (err_cnt_o !== mdl_err) begin errors++; $display("FAIL oor_first_cnt: got %0d want %0d", err_cnt_o, mdl_err); end
    for (int i = 1; i < 300; i++) tick();
`ifdef OPSEL_ERRCNT_EN
    exp_sat = 8'd255;
`else
    exp_sat = '0;
`endif
    checks++; if (err_cnt_o !== exp_sat) begin errors++; $display("FAIL oor_saturate: got %0d want %0d", err_cnt_o, exp_sat); end
    set_in(1'b0, '0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_stall();
    set_src(32'h11, 32'h22, 32'h33);
    set_in(1'b1, 2'd2, 1'b0, 1'b1);
    tick();
    checks++; if (data_o !== 32'h33) begin errors++; $display("FAIL stall_load: got %h want 33", data_o); end
    for (int i = 0; i < 4; i++) begin
      set_src($urandom, $urandom, $urandom);
      set_in(1'b1, SEL_W'(i), 1'b0, 1'b0);
      checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL stall_ready: got %0b want 0", ready_o); end
      tick();
      checks++; if (valid_o !== 1'b1 || data_o !== 32'h33 || sel_o !== 2'd2) begin
        errors++; $display("FAIL stall_hold: got %0b/%h/%0d want 1/33/2", valid_o, data_o, sel_o);
      end
    end
    set_src(32'h11, 32'h22, 32'h33);
    set_in(1'b1, 2'd1, 1'b0, 1'b1);
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %0b want 1", ready_o); end
    tick();
    checks++; if (valid_o !== 1'b1 || data_o !== 32'h22 || sel_o !== 2'd1) begin
      errors++; $display("FAIL stall_release: got %0b/%h/%0d want 1/22/1", valid_o, data_o, sel_o);
    end
  endtask

  task automatic test_flush();
    logic [ERR_W-1:0] err_before;
    set_src(32'h11, 32'h22, 32'h33);
    set_in(1'b1, 2'd2, 1'b0, 1'b1);
    tick();
    set_in(1'b0, '0, 1'b0, 1'b0);
    tick();
    err_before = err_cnt_o;
    set_in(1'b1, 2'd1, 1'b1, 1'b0);
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL flush_ready: got %0b want 0", ready_o); end
    tick();
    checks++; if (valid_o !== 1'b0 || data_o !== 32'h33 || sel_o !== 2'd2) begin
      errors++; $display("FAIL flush_drop: got %0b/%h/%0d want 0/33/2", valid_o, data_o, sel_o);
    end
    set_in(1'b1, 2'd3, 1'b1, 1'b1);
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL flush_ready_idle: got %0b want 0", ready_o); end
    tick();
    checks++; if (valid_o !== 1'b0 || err_cnt_o !== err_before) begin
      errors++; $display("FAIL flush_nocount: got %0b/%0d want 0/%0d", valid_o, err_cnt_o, err_before);
    end
    set_in(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_stall();
    set_src(32'h11, 32'h22, 32'h33);
    set_in(1'b1, 2'd3, 1'b0, 1'b1);
    tick();
    set_in(1'b1, 2'd2, 1'b0, 1'b0);
    tick();
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL rststall_pre: got %0b want 1", valid_o); end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    set_in(1'b0, '0, 1'b0, 1'b0);
    checks++; if (valid_o !== 1'b0 || data_o !== '0 || sel_o !== '0 || err_cnt_o !== '0) begin
      errors++; $display("FAIL rststall_state: got %0b/%h/%0d/%0d want 0/0/0/0", valid_o, data_o, sel_o, err_cnt_o);
    end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL rststall_ready: got %0b want 1", ready_o); end
  endtask

  task automatic test_back_to_back();
    logic v, f, r, exp_rdy;
    logic [SEL_W-1:0] s;
    for (int i = 0; i < 80; i++) begin
      v = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 9) == 0);
      r = ($urandom_range(0, 3) != 0);
      s = SEL_W'($urandom_range(0, 3));
      set_src($urandom, $urandom, $urandom);
      set_in(v, s, f, r);
      exp_rdy = !f && (!mdl_valid || r);
      checks++; if (ready_o !== exp_rdy) begin errors++; $display("FAIL b2b_ready[%0d]: got %0b want %0b", i, ready_o, exp_rdy); end
      tick();
      checks++;
      if (valid_o !== mdl_valid || data_o !== last.data || sel_o !== last.sel || err_cnt_o !== mdl_err) begin
        errors++;
        $display("FAIL b2b_out[%0d]: got %0b/%h/%0d/%0d want %0b/%h/%0d/%0d", i,
                 valid_o, data_o, sel_o, err_cnt_o, mdl_valid, last.data, last.sel, mdl_err);
      end
    end
    set_in(1'b0, '0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_wide();
    logic [63:0] exp_d;
    for (int k = 0; k < W_NUM; k++) w_data_i[k*W_WIDTH +: W_WIDTH] = 64'(k) * W_STEP;
    for (int k = 0; k < W_NUM; k++) begin
      w_valid_i  = 1'b1;
      w_select_i = W_SEL'(k);
      #1;
      checks++; if (w_ready_o !== 1'b1) begin errors++; $display("FAIL wide_ready[%0d]: got %0b want 1", k, w_ready_o); end
      @(posedge clk);
      #1;
      exp_d = 64'(k) * W_STEP;
      checks++; if (w_valid_o !== 1'b1 || w_data_o !== exp_d || w_sel_o !== W_SEL'(k)) begin
        errors++; $display("FAIL wide_sel[%0d]: got %0b/%h/%0d want 1/%h/%0d", k, w_valid_o, w_data_o, w_sel_o, exp_d, k);
      end
    end
    w_valid_i = 1'b0;
    checks++; if (w_err_cnt_o !== '0) begin errors++; $display("FAIL wide_err: got %0d want 0", w_err_cnt_o); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i      = 1'b1;
    valid_i    = 1'b0;
    flush_i    = 1'b0;
    ready_i    = 1'b1;
    select_i   = '0;
    data_i     = '0;
    w_valid_i  = 1'b0;
    w_flush_i  = 1'b0;
    w_ready_i  = 1'b1;
    w_select_i = '0;
    w_data_i   = '0;
    mdl_valid  = 1'b0;
    mdl_err    = '0;
    last       = '0;

    test_reset();
    test_basic();
    test_out_of_range();
    test_stall();
    test_flush();
    test_reset_mid_stall();
    test_back_to_back();
    test_wide();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/opsel_pipe.md
# opsel_pipe

Parametrised N-way operand-select register for the pipelined CPU datapath: picks one of NUM_IN operand sources by index and registers the result with a valid/ready handshake, stall hold and flush. It supersedes the fixed three-input forwarding multiplexers in the EX stage. Width, source count and select width are parameters. Out-of-range selects fall back to source 0, matching the existing forwarding-mux default.

## Interface
- WIDTH, 32: operand width in bits
- NUM_IN, 3: number of sources, 2..16
- SEL_W, 2: select width, must satisfy 2**SEL_W >= NUM_IN
- ERR_W, 8: width of the error counter (used only with OPSEL_ERRCNT_EN)

Ports:
- clk_i  in  1  clock; all state changes on the rising edge
- rst_i  in  1  synchronous, active-high reset
- valid_i  in  1  upstream has a transaction this cycle
- ready_o  out  1  block accepts a transaction this cycle
- data_i  in  NUM_IN*WIDTH  sources packed; source k = data_i[k*WIDTH +: WIDTH]
- select_i  in  SEL_W  source index
- flush_i  in  1  discard the held and incoming transaction
- valid_o  out  1  data_o/sel_o hold a valid result
- ready_i  in  1  downstream consumes the result
- data_o  out  WIDTH  registered selected operand
- sel_o  out  SEL_W  registered effective index (0 when the select was out of range)
- err_cnt_o  out  ERR_W  saturating count of out-of-range selects

## Operation
- Effective index: eff = select_i if select_i < NUM_IN, else 0.
- ready_o = !flush_i && (!valid_o || ready_i). This is combinational and contains no path from valid_i.
- Accept when valid_i && ready_o. On the next edge: data_o <= source[eff], sel_o <= eff, valid_o <= 1.
- Consume when valid_o && ready_i and no accept in the same cycle: valid_o <= 0. data_o and sel_o keep their last value.
- Consume and accept in the same cycle: the new result replaces the old one and valid_o stays 1. Throughput is one transaction per cycle.
- Stall (valid_o && !ready_i): data_o, sel_o and valid_o hold. ready_o = 0. Source and select changes are ignored.
- Flush: on the next edge valid_o <= 0. flush_i has priority over accept and hold. data_o and sel_o are not cleared.
- rst_i has priority over everything. It sets valid_o=0, data_o=0, sel_o=0 and err_cnt_o=0. A transaction held when reset is asserted is lost.
- valid_i without ready_o is not accepted. Upstream must hold the transaction, as in AXI-style handshakes.

## Timing
- Latency: an accept at edge n produces valid_o/data_o in the cycle after edge n (1 cycle).
- Combinational paths: ready_o depends only on flush_i, valid_o and ready_i. There are no combinational paths from data_i or select_i to any output.
- Reset values: valid_o=0, data_o=0, sel_o=0, err_cnt_o=0. ready_o=1 after reset whenever flush_i=0.

## Configuration
- OPSEL_ERRCNT_EN defined:
  - err_cnt_o increments by 1 on each accepted transaction with select_i >= NUM_IN.
  - It saturates at 2**ERR_W-1.
  - Only rst_i clears it; flush_i does not.
  - A flushed-cycle offer is not accepted and does not count.
- OPSEL_ERRCNT_EN undefined:
  - err_cnt_o is tied to 0 and no counter register is built.
  - The port list is unchanged.
  - The fallback-to-source-0 behaviour is identical in both builds.

## Test plan
- **Basic select:** NUM_IN=3, sources 0x11/0x22/0x33, ready_i=1; select 0,1,2 on consecutive cycles -> data_o 0x11,0x22,0x33 one cycle later, valid_o stays 1, sel_o 0,1,2.
- **Out-of-range select:** select_i=3 -> data_o=0x11, sel_o=0. With OPSEL_ERRCNT_EN, err_cnt_o goes 0->1; repeat 300 times with ERR_W=8 -> err_cnt_o=255.
- **Stall:** accept select=2 (data_o=0x33), then ready_i=0 for 4 cycles while sources change -> data_o stays 0x33, valid_o=1, ready_o=0. Raise ready_i with valid_i=1, select=1 -> next cycle data_o=0x22.
- **Flush:** flush_i=1 in the same cycle as valid_i=1, select=1 while holding 0x33 -> ready_o=0, next cycle valid_o=0, nothing accepted, err_cnt_o unchanged.
- **Reset mid-stall:** valid_o=1, ready_i=0, then rst_i=1 for 1 cycle -> valid_o=0, data_o=0, sel_o=0, err_cnt_o=0, ready_o=1.
- **Wide config:** WIDTH=64, NUM_IN=16, SEL_W=4; sweep select 0..15 with source k = k*0x0101010101010101 -> each result matches its source, no counter increments.
